// File: rtl/wci_timeout_guard.sv
// wci_timeout_guard: single-outstanding WCI request guard that turns a silent target into an ERR response; statistics built only with WCI_GUARD_STATS_EN
module wci_timeout_guard #(
  parameter int unsigned TIMEOUT = 1024,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_0BAD
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wciS0_MReset_n,
  input  logic [2:0]  wciS0_MCmd,
  input  logic        wciS0_MAddrSpace,
  input  logic [3:0]  wciS0_MByteEn,
  input  logic [19:0] wciS0_MAddr,
  input  logic [31:0] wciS0_MData,
  output logic [1:0]  wciS0_SResp,
  output logic [31:0] wciS0_SData,
  output logic        wciS0_SThreadBusy,
  output logic [1:0]  wciS0_SFlag,
  input  logic [1:0]  wciS0_MFlag,
  output logic        wciM0_MReset_n,
  output logic [2:0]  wciM0_MCmd,
  output logic        wciM0_MAddrSpace,
  output logic [3:0]  wciM0_MByteEn,
  output logic [19:0] wciM0_MAddr,
  output logic [31:0] wciM0_MData,
  input  logic [1:0]  wciM0_SResp,
  input  logic [31:0] wciM0_SData,
  input  logic        wciM0_SThreadBusy,
  input  logic [1:0]  wciM0_SFlag,
  output logic [1:0]  wciM0_MFlag,
  input  logic        stats_clear,
  output logic        timeout_sticky,
  output logic [7:0]  timeout_count,
  output logic [19:0] timeout_addr
);
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);
  state_t state, state_nxt;
  logic [15:0] cnt;
  logic flush, accept, resp_seen, at_limit, fwd, timeout_evt;
  assign flush = RST | ~wciS0_MReset_n;
  assign wciM0_MReset_n = wciS0_MReset_n & ~RST;
  assign wciS0_SThreadBusy = (state != IDLE) | wciM0_SThreadBusy | ~wciS0_MReset_n;
  assign wciS0_SFlag = wciM0_SFlag;
  assign wciM0_MFlag = wciS0_MFlag;
  assign accept = (state == IDLE) && (wciS0_MCmd != 3'd0) && !wciS0_SThreadBusy;
  assign resp_seen = wciM0_SResp != 2'd0;
  assign at_limit = cnt == LIMIT;
  assign fwd = (state == BUSY) && resp_seen;
  // Next state; a link reset abandons whatever is in flight, a response beats the limit
  always_comb begin
    state_nxt = state;
    timeout_evt = 1'b0;
    if (!wciS0_MReset_n) state_nxt = IDLE;
    else
      case (state)
        IDLE: state_nxt = accept ? BUSY : IDLE;
        BUSY: begin
          state_nxt = resp_seen ? IDLE : at_limit ? DRAIN : BUSY;
          timeout_evt = !resp_seen && at_limit;
        end
        DRAIN: state_nxt = (resp_seen || at_limit) ? IDLE : DRAIN;
        default: state_nxt = IDLE;
      endcase
  end
  // State register
  always_ff @(posedge CLK)
    if (RST) state <= IDLE;
    else state <= state_nxt;
  // Wait counter runs only while staying in BUSY or DRAIN, so every entry starts at zero
  always_ff @(posedge CLK)
    if (RST) cnt <= '0;
    else cnt <= (state_nxt == state && state != IDLE) ? cnt + 16'd1 : '0;
  // Downstream request: command pulses for one cycle, fields held for the timeout record
  always_ff @(posedge CLK)
    if (flush) begin
      wciM0_MCmd <= '0;
      wciM0_MAddrSpace <= '0;
      wciM0_MByteEn <= '0;
      wciM0_MAddr <= '0;
      wciM0_MData <= '0;
    end else if (accept) begin
      wciM0_MCmd <= wciS0_MCmd;
      wciM0_MAddrSpace <= wciS0_MAddrSpace;
      wciM0_MByteEn <= wciS0_MByteEn;
      wciM0_MAddr <= wciS0_MAddr;
      wciM0_MData <= wciS0_MData;
    end else wciM0_MCmd <= 3'd0;
  // Upstream response: forwarded target response or synthesized ERR, always a single cycle
  always_ff @(posedge CLK)
    if (flush) begin
      wciS0_SResp <= '0;
      wciS0_SData <= '0;
    end else begin
      wciS0_SResp <= fwd ? wciM0_SResp : timeout_evt ? 2'd3 : 2'd0;
      wciS0_SData <= fwd ? wciM0_SData : timeout_evt ? TIMEOUT_DATA : '0;
    end
`ifdef WCI_GUARD_STATS_EN
  // Timeout statistics; a clear wins over a timeout in the same cycle
  always_ff @(posedge CLK)
    if (RST || stats_clear) begin
      timeout_sticky <= 1'b0;
      timeout_count <= '0;
      timeout_addr <= '0;
    end else if (timeout_evt) begin
      timeout_sticky <= 1'b1;
      timeout_count <= (timeout_count == 8'hFF) ? timeout_count : timeout_count + 8'd1;
      timeout_addr <= wciM0_MAddr;
    end
`else
  logic unused_stats_clear;
  assign unused_stats_clear = stats_clear;
  assign timeout_sticky = 1'b0;
  assign timeout_count = '0;
  assign timeout_addr = '0;
`endif
endmodule

// File: tb/tb_wci_timeout_guard.sv
// tb_wci_timeout_guard: table vectors, directed corner sequences and a timestamp-based random model for wci_timeout_guard
module tb_wci_timeout_guard;
  localparam int TO = 8;
  localparam logic [31:0] TD = 32'hDEAD_0BAD;
`ifdef WCI_GUARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic s_reset_n, s_space, s_stb, m_reset_n, m_space, m_stb, clr, sticky;
  logic [2:0] s_cmd, m_cmd;
  logic [3:0] s_be, m_be;
  logic [19:0] s_addr, m_addr, taddr;
  logic [31:0] s_data, s_sdata, m_data, m_sdata;
  logic [1:0] s_resp, m_resp, s_sflag, s_mflag, m_sflag, m_mflag;
  logic [7:0] tcount;
  int n_vec = 0, n_err = 0;
  typedef struct {
    logic [2:0] cmd; logic [19:0] addr; logic [1:0] mresp; logic [31:0] mdata;
    logic [1:0] e_resp; logic [31:0] e_data; logic e_stb; logic [2:0] e_mcmd;
  } vec_t;
  vec_t tbl [16];
  bit out_q, drn_q, e_sticky, busy, to_evt;
  int acc_t, drn_t, t, e_cnt, errs;
  logic [1:0] e_resp, n_resp;
  logic [31:0] e_sd, n_sd, e_md;
  logic [2:0] e_cmd, n_cmd;
  logic e_sp;
  logic [3:0] e_be;
  logic [19:0] e_ad, req_ad, e_taddr;

  always #5 clk = ~clk;

  wci_timeout_guard #(.TIMEOUT(TO), .TIMEOUT_DATA(TD)) dut (
    .CLK(clk), .RST(rst), .wciS0_MReset_n(s_reset_n), .wciS0_MCmd(s_cmd),
    .wciS0_MAddrSpace(s_space), .wciS0_MByteEn(s_be), .wciS0_MAddr(s_addr), .wciS0_MData(s_data),
    .wciS0_SResp(s_resp), .wciS0_SData(s_sdata), .wciS0_SThreadBusy(s_stb),
    .wciS0_SFlag(s_sflag), .wciS0_MFlag(s_mflag), .wciM0_MReset_n(m_reset_n), .wciM0_MCmd(m_cmd),
    .wciM0_MAddrSpace(m_space), .wciM0_MByteEn(m_be), .wciM0_MAddr(m_addr), .wciM0_MData(m_data),
    .wciM0_SResp(m_resp), .wciM0_SData(m_sdata), .wciM0_SThreadBusy(m_stb), .wciM0_SFlag(m_sflag),
    .wciM0_MFlag(m_mflag), .stats_clear(clr), .timeout_sticky(sticky), .timeout_count(tcount),
    .timeout_addr(taddr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] cmd, input logic [19:0] addr, input logic [1:0] mresp,
                              input logic [31:0] mdata, input logic [1:0] e_r, input logic [31:0] e_d,
                              input logic e_s, input logic [2:0] e_m);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.mresp = mresp; v.mdata = mdata;
    v.e_resp = e_r; v.e_data = e_d; v.e_stb = e_s; v.e_mcmd = e_m;
    return v;
  endfunction

  initial begin
    tbl[0] = mk(3'd2, 20'h00ABC, 2'd0, 32'd0, 2'd0, 32'd0, 1'b0, 3'd0);
    tbl[1] = mk(3'd0, 20'h0, 2'd0, 32'd0, 2'd0, 32'd0, 1'b1, 3'd2);
    tbl[2] = mk(3'd0, 20'h0, 2'd0, 32'd0, 2'd0, 32'd0, 1'b1, 3'd0);
    tbl[3] = mk(3'd0, 20'h0, 2'd1, 32'h1234_5678, 2'd0, 32'd0, 1'b1, 3'd0);
    tbl[4] = mk(3'd0, 20'h0, 2'd0, 32'd0, 2'd1, 32'h1234_5678, 1'b0, 3'd0);
    tbl[5] = mk(3'd1, 20'h12345, 2'd0, 32'd0, 2'd0, 32'd0, 1'b0, 3'd0);
    for (int i = 6; i <= 12; i++) tbl[i] = mk(3'd0, 20'h0, 2'd0, 32'd0, 2'd0, 32'd0, 1'b1, (i == 6) ? 3'd1 : 3'd0);
    tbl[13] = mk(3'd0, 20'h0, 2'd1, 32'hCAFE_F00D, 2'd0, 32'd0, 1'b1, 3'd0);
    tbl[14] = mk(3'd0, 20'h0, 2'd0, 32'd0, 2'd1, 32'hCAFE_F00D, 1'b0, 3'd0);
    tbl[15] = mk(3'd0, 20'h0, 2'd0, 32'd0, 2'd0, 32'd0, 1'b0, 3'd0);
    s_reset_n = 1'b1; s_cmd = '0; s_space = 1'b0; s_be = 4'hF; s_addr = '0; s_data = 32'h0000_00A5;
    m_resp = '0; m_sdata = '0; m_stb = 1'b0; m_sflag = '0; s_mflag = '0; clr = 1'b0;
    tick();
    tick();
    chk("rst.sresp", 32'(s_resp), 0);
    chk("rst.sdata", s_sdata, 0);
    chk("rst.mcmd", 32'(m_cmd), 0);
    chk("rst.maddr", 32'(m_addr), 0);
    chk("rst.mdata", m_data, 0);
    chk("rst.mbe", 32'(m_be), 0);
    chk("rst.mreset_n", 32'(m_reset_n), 0);
    chk("rst.stb", 32'(s_stb), 0);
    chk("rst.sticky", 32'(sticky), 0);
    chk("rst.count", 32'(tcount), 0);
    chk("rst.taddr", 32'(taddr), 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      s_cmd = tbl[i].cmd; s_addr = tbl[i].addr; m_resp = tbl[i].mresp; m_sdata = tbl[i].mdata;
      #1;
      chk($sformatf("tbl%0d.sresp", i), 32'(s_resp), 32'(tbl[i].e_resp));
      if (tbl[i].e_resp != 2'd0) chk($sformatf("tbl%0d.sdata", i), s_sdata, tbl[i].e_data);
      chk($sformatf("tbl%0d.stb", i), 32'(s_stb), 32'(tbl[i].e_stb));
      chk($sformatf("tbl%0d.mcmd", i), 32'(m_cmd), 32'(tbl[i].e_mcmd));
      tick();
    end
    chk("lim.count", 32'(tcount), 0);
    s_cmd = 3'd1; s_addr = 20'h0BEEF;
    tick();
    s_cmd = 3'd0;
    #1;
    chk("to.mcmd", 32'(m_cmd), 1);
    chk("to.maddr", 32'(m_addr), 32'h0BEEF);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) #1;
      chk($sformatf("to.wait%0d", k), 32'(s_resp), 0);
      tick();
    end
    #1;
    chk("to.sresp", 32'(s_resp), 3);
    chk("to.sdata", s_sdata, TD);
    chk("to.count", 32'(tcount), STATS ? 1 : 0);
    chk("to.taddr", 32'(taddr), STATS ? 32'h0BEEF : 0);
    chk("to.sticky", 32'(sticky), STATS ? 1 : 0);
    tick();
    m_resp = 2'd1; m_sdata = 32'h7777_7777;
    #1;
    chk("drain.stb", 32'(s_stb), 1);
    tick();
    m_resp = 2'd0; s_cmd = 3'd2; s_addr = 20'h00777;
    #1;
    chk("drain.sresp", 32'(s_resp), 0);
    chk("drain.stb_free", 32'(s_stb), 0);
    tick();
    s_cmd = 3'd0; m_resp = 2'd1; m_sdata = 32'h0BAD_F00D;
    #1;
    chk("drain.next_cmd", 32'(m_cmd), 2);
    chk("drain.next_addr", 32'(m_addr), 32'h00777);
    tick();
    m_resp = 2'd0;
    #1;
    chk("drain.next_resp", 32'(s_resp), 1);
    chk("drain.next_data", s_sdata, 32'h0BAD_F00D);
    s_cmd = 3'd2; s_addr = 20'h00A5A;
    errs = 0;
    for (int k = 0; k < 6000 && errs < 300; k++) begin
      #1;
      if (s_resp == 2'd3) errs++;
      tick();
    end
    chk("sat.errs", 32'(errs), 300);
    s_cmd = 3'd0;
    repeat (20) tick();
    chk("sat.count", 32'(tcount), STATS ? 255 : 0);
    chk("sat.sticky", 32'(sticky), STATS ? 1 : 0);
    s_cmd = 3'd1; s_addr = 20'h00321;
    tick();
    s_cmd = 3'd0;
    repeat (7) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    chk("clr.sresp", 32'(s_resp), 3);
    chk("clr.count", 32'(tcount), 0);
    chk("clr.sticky", 32'(sticky), 0);
    repeat (10) tick();
    s_cmd = 3'd2; s_addr = 20'h00111;
    tick();
    s_cmd = 3'd0;
    tick();
    s_reset_n = 1'b0;
    #1;
    chk("lr.mreset_n", 32'(m_reset_n), 0);
    chk("lr.stb", 32'(s_stb), 1);
    tick();
    s_reset_n = 1'b1; m_resp = 2'd1; m_sdata = 32'h1111_1111;
    #1;
    chk("lr.sresp", 32'(s_resp), 0);
    chk("lr.mcmd", 32'(m_cmd), 0);
    chk("lr.stb", 32'(s_stb), 0);
    tick();
    m_resp = 2'd0; s_cmd = 3'd1; s_addr = 20'h00222;
    #1;
    chk("lr.absorbed", 32'(s_resp), 0);
    tick();
    s_cmd = 3'd0;
    #1;
    chk("lr.next_cmd", 32'(m_cmd), 1);
    chk("lr.next_addr", 32'(m_addr), 32'h00222);
    tick();
    m_resp = 2'd1; m_sdata = 32'h55AA_55AA;
    tick();
    m_resp = 2'd0;
    #1;
    chk("lr.next_resp", 32'(s_resp), 1);
    chk("lr.next_data", s_sdata, 32'h55AA_55AA);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    out_q = 0; drn_q = 0; e_sticky = 0; e_cnt = 0; e_taddr = '0; t = 0; acc_t = 0; drn_t = 0;
    e_resp = '0; e_sd = '0; e_cmd = '0; e_sp = 0; e_be = '0; e_ad = '0; e_md = '0; req_ad = '0;
    for (int c = 0; c < 3000; c++) begin
      s_cmd = ($urandom_range(1, 0) == 0) ? 3'd0 : 3'($urandom_range(2, 1));
      s_space = 1'($urandom); s_be = 4'($urandom); s_addr = 20'($urandom); s_data = $urandom;
      m_resp = ($urandom_range(11, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
      m_sdata = $urandom; m_stb = ($urandom_range(9, 0) == 0);
      s_reset_n = ($urandom_range(59, 0) != 0); clr = ($urandom_range(79, 0) == 0);
      s_mflag = 2'($urandom); m_sflag = 2'($urandom);
      #1;
      busy = out_q | drn_q | m_stb | ~s_reset_n;
      chk("rnd.stb", 32'(s_stb), 32'(busy));
      chk("rnd.sresp", 32'(s_resp), 32'(e_resp));
      if (e_resp != 2'd0) chk("rnd.sdata", s_sdata, e_sd);
      chk("rnd.mcmd", 32'(m_cmd), 32'(e_cmd));
      if (e_cmd != 3'd0) begin
        chk("rnd.maddr", 32'(m_addr), 32'(e_ad));
        chk("rnd.mdata", m_data, e_md);
        chk("rnd.mbe", 32'(m_be), 32'(e_be));
        chk("rnd.mspace", 32'(m_space), 32'(e_sp));
      end
      chk("rnd.mreset_n", 32'(m_reset_n), 32'(s_reset_n));
      chk("rnd.flags", {28'd0, m_mflag, s_sflag}, {28'd0, s_mflag, m_sflag});
      chk("rnd.count", 32'(tcount), STATS ? 32'(e_cnt) : 0);
      chk("rnd.sticky", 32'(sticky), STATS ? 32'(e_sticky) : 0);
      chk("rnd.taddr", 32'(taddr), STATS ? 32'(e_taddr) : 0);
      n_resp = '0; n_sd = '0; n_cmd = '0; to_evt = 0;
      if (!s_reset_n) begin
        out_q = 0; drn_q = 0;
      end else if (out_q) begin
        if (m_resp != 2'd0) begin
          n_resp = m_resp; n_sd = m_sdata; out_q = 0;
        end else if (t - acc_t == TO) begin
          n_resp = 2'd3; n_sd = TD; out_q = 0; drn_q = 1; drn_t = t + 1; to_evt = 1;
        end
      end else if (drn_q) begin
        if (m_resp != 2'd0 || t - drn_t == TO - 1) drn_q = 0;
      end else if (s_cmd != 3'd0 && !busy) begin
        out_q = 1; acc_t = t; n_cmd = s_cmd;
        e_sp = s_space; e_be = s_be; e_ad = s_addr; e_md = s_data; req_ad = s_addr;
      end
      if (clr) begin
        e_sticky = 0; e_cnt = 0; e_taddr = '0;
      end else if (to_evt) begin
        e_sticky = 1; e_cnt = (e_cnt < 255) ? e_cnt + 1 : 255; e_taddr = req_ad;
      end
      e_resp = n_resp; e_sd = n_sd; e_cmd = n_cmd; t++;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
